// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline hazard
// controller.
//   Signal   : single control bit
//   RegAddr  : 5-bit register-file address
//   FwdSel   : E-stage operand forward select (NONE/E/M/W)
//   SbEntry  : scoreboard slot {valid, rd, load}
//   HAZARD_DEPTH : slots tracked after decode (E, M, W)
package hazard_ctrl_pkg;

  typedef logic       Signal;
  typedef logic [4:0] RegAddr;

  localparam int unsigned HAZARD_DEPTH = 3;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_E    = 2'd1,
    FWD_M    = 2'd2,
    FWD_W    = 2'd3
  } FwdSel;

  typedef struct packed {
    Signal  valid;
    RegAddr rd;
    Signal  load;
  } SbEntry;

  // Scoreboard slot index to forward source; slots past W cannot forward.
  function automatic FwdSel slot_to_fwd(input int unsigned k);
    FwdSel sel;
    case (k)
      0:       sel = FWD_E;
      1:       sel = FWD_M;
      2:       sel = FWD_W;
      default: sel = FWD_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: DEPTH-entry shift register of destination registers
// owned by in-flight instructions (slot 0 = E, 1 = M, 2 = W).
//   clk, reset      : clock, synchronous active-high reset (clears slots)
//   push            : entry loaded into slot 0 every clock
//   qa, qb          : two query register addresses
//   match_a/match_b : per-slot hit (slot valid, query != r0, rd == query)
//   lmatch_a/_b     : per-slot hit where the owning instruction is a load
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = HAZARD_DEPTH
) (
  input  logic             clk,
  input  Signal            reset,
  input  SbEntry           push,
  input  RegAddr           qa,
  input  RegAddr           qb,
  output logic [DEPTH-1:0] match_a,
  output logic [DEPTH-1:0] match_b,
  output logic [DEPTH-1:0] lmatch_a,
  output logic [DEPTH-1:0] lmatch_b
);

  SbEntry slot_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q[0] <= push;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        slot_q[i] <= slot_q[i-1];
      end
    end
  end

  always_comb begin
    match_a  = '0;
    match_b  = '0;
    lmatch_a = '0;
    lmatch_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_a[i]  = slot_q[i].valid && (qa != '0) && (slot_q[i].rd == qa);
      match_b[i]  = slot_q[i].valid && (qb != '0) && (slot_q[i].rd == qb);
      lmatch_a[i] = match_a[i] && slot_q[i].load;
      lmatch_b[i] = match_b[i] && slot_q[i].load;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection, decode-stage stall/bubble/flush
// sequencing and optional operand forwarding selects.
// Build option: define HAZARD_FORWARDING_EN to enable forwarding (only
// load-use stalls, fwd_rs/fwd_rt driven). Undefined: every RAW match in
// E/M/W stalls and fwd_rs/fwd_rt are NONE.
//   clk, reset           : clock, synchronous active-high reset
//   d_valid              : decode holds a real instruction
//   d_rs, d_rt           : decode source addresses
//   d_rs_used, d_rt_used : instruction actually reads rs / rt
//   d_rd, d_wr, d_load   : destination, writes-rd, is-load
//   redirect             : E resolved a taken branch/jump this cycle
//   stall_fd             : hold PC and F/D register
//   bubble_e             : load a NOP into D/E
//   flush_d              : squash F/D contents
//   fwd_rs, fwd_rt       : E-stage forward selects
//   stall_cnt            : saturating count of stall cycles
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = HAZARD_DEPTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  Signal            reset,
  input  Signal            d_valid,
  input  RegAddr           d_rs,
  input  RegAddr           d_rt,
  input  Signal            d_rs_used,
  input  Signal            d_rt_used,
  input  RegAddr           d_rd,
  input  Signal            d_wr,
  input  Signal            d_load,
  input  Signal            redirect,
  output Signal            stall_fd,
  output Signal            bubble_e,
  output Signal            flush_d,
  output FwdSel            fwd_rs,
  output FwdSel            fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  SbEntry           push;
  logic [DEPTH-1:0] match_rs, match_rt, lmatch_rs, lmatch_rt;
  logic [DEPTH-1:0] hit_rs, hit_rt, lhit_rs, lhit_rt;
  logic             rs_chk, rt_chk;
  logic             hazard;
  FwdSel            sel_rs, sel_rt;
  logic [CNT_W-1:0] cnt_q;

  hazard_scoreboard #(
    .DEPTH (DEPTH)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .qa       (d_rs),
    .qb       (d_rt),
    .match_a  (match_rs),
    .match_b  (match_rt),
    .lmatch_a (lmatch_rs),
    .lmatch_b (lmatch_rt)
  );

  // A stalled or redirected decode instruction does not advance, so it
  // enters E as a bubble.
  always_comb begin
    push       = '0;
    push.valid = d_valid && d_wr && (d_rd != '0) && !stall_fd && !redirect;
    push.rd    = d_rd;
    push.load  = d_load;
  end

  always_comb begin
    rs_chk  = d_valid && d_rs_used;
    rt_chk  = d_valid && d_rt_used;
    hit_rs  = match_rs  & {DEPTH{rs_chk}};
    hit_rt  = match_rt  & {DEPTH{rt_chk}};
    lhit_rs = lmatch_rs & {DEPTH{rs_chk}};
    lhit_rt = lmatch_rt & {DEPTH{rt_chk}};
  end

`ifdef HAZARD_FORWARDING_EN
  // Youngest producer wins: E over M over W.
  function automatic FwdSel pick_fwd(input logic [DEPTH-1:0] hit);
    FwdSel sel;
    sel = FWD_NONE;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (hit[k] && (sel == FWD_NONE)) begin
        sel = slot_to_fwd(k);
      end
    end
    return sel;
  endfunction

  localparam logic [DEPTH-1:0] SLOT_E = DEPTH'(1);

  always_comb begin
    // Only a load still in E cannot be forwarded in time.
    hazard = |((lhit_rs | lhit_rt) & SLOT_E);
    sel_rs = pick_fwd(hit_rs);
    sel_rt = pick_fwd(hit_rt);
  end
`else
  always_comb begin
    // Load hits are a subset of plain hits; folding them in changes nothing.
    hazard = |(hit_rs | hit_rt | lhit_rs | lhit_rt);
    sel_rs = FWD_NONE;
    sel_rt = FWD_NONE;
  end
`endif

  // Redirect outranks a hazard: the decode instruction is dead anyway.
  always_comb begin
    stall_fd = !reset && hazard && !redirect;
    bubble_e = !reset && (hazard || redirect);
    flush_d  = !reset && redirect;
    fwd_rs   = reset ? FWD_NONE : sel_rs;
    fwd_rt   = reset ? FWD_NONE : sel_rt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (stall_fd && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid, d_rs_used, d_rt_used, d_wr, d_load, redirect;
  logic [4:0]  d_rs, d_rt, d_rd;
  logic        stall_fd, bubble_e, flush_d;
  logic [1:0]  fwd_rs, fwd_rt;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .DEPTH (3),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_valid   (d_valid),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_rs_used (d_rs_used),
    .d_rt_used (d_rt_used),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_load    (d_load),
    .redirect  (redirect),
    .stall_fd  (stall_fd),
    .bubble_e  (bubble_e),
    .flush_d   (flush_d),
    .fwd_rs    (fwd_rs),
    .fwd_rt    (fwd_rt),
    .stall_cnt (stall_cnt)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model: list of accepted writers tagged with their decode cycle. A writer
  // decoded in cycle c is age 1 (E) in c+1, age 2 (M) in c+2, age 3 (W) in c+3.
  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    bit          ld;
  } prod_t;

  typedef struct packed {
    bit       stall;
    bit       bubble;
    bit       flush;
    bit [1:0] frs;
    bit [1:0] frt;
    bit       accept;
  } exp_t;

  prod_t       hist[$];
  int unsigned now  = 0;
  int unsigned mcnt = 0;
  exp_t        ecmp;
  exp_t        eupd;

  function automatic bit [1:0] youngest_age(input logic [4:0] a, output bit is_load);
    int unsigned best;
    best    = 0;
    is_load = 1'b0;
    if (a != 5'd0) begin
      foreach (hist[i]) begin
        int unsigned age;
        age = now - hist[i].cyc;
        if (age >= 1 && age <= 3 && hist[i].rd == a && (best == 0 || age < best)) begin
          best    = age;
          is_load = hist[i].ld;
        end
      end
    end
    return 2'(best);
  endfunction

  function automatic exp_t model();
    exp_t     e;
    bit       lrs, lrt, haz;
    bit [1:0] ars, art;
    lrs = 1'b0;
    lrt = 1'b0;
    ars = 2'd0;
    art = 2'd0;
    if (d_valid && d_rs_used) ars = youngest_age(d_rs, lrs);
    if (d_valid && d_rt_used) art = youngest_age(d_rt, lrt);
    if (FWD) haz = (ars == 2'd1 && lrs) || (art == 2'd1 && lrt);
    else     haz = (ars != 2'd0) || (art != 2'd0);
    e.stall  = !reset && haz && !redirect;
    e.bubble = !reset && (haz || redirect);
    e.flush  = !reset && redirect;
    e.frs    = (FWD && !reset) ? ars : 2'd0;
    e.frt    = (FWD && !reset) ? art : 2'd0;
    e.accept = d_valid && d_wr && (d_rd != 5'd0) && !e.stall && !redirect;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    ecmp = model();
    check("stall_fd",  32'(stall_fd),  32'(ecmp.stall));
    check("bubble_e",  32'(bubble_e),  32'(ecmp.bubble));
    check("flush_d",   32'(flush_d),   32'(ecmp.flush));
    check("fwd_rs",    32'(fwd_rs),    32'(ecmp.frs));
    check("fwd_rt",    32'(fwd_rt),    32'(ecmp.frt));
    check("stall_cnt", 32'(stall_cnt), mcnt);
  end

  // Model state update at the active edge.
  always @(posedge clk) begin
    eupd = model();
    if (reset) begin
      hist.delete();
      mcnt <= 0;
    end else begin
      if (eupd.accept) hist.push_back('{now, d_rd, d_load});
      if (eupd.stall && mcnt != 32'hFFFF) mcnt <= mcnt + 1;
    end
    while (hist.size() > 0 && (now + 1) - hist[0].cyc > 3) void'(hist.pop_front());
    now <= now + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [4:0] rs, input bit rsu,
                        input logic [4:0] rt, input bit rtu, input logic [4:0] rd,
                        input bit wr, input bit ld, input bit redir);
    d_valid = v;   d_rs = rs; d_rs_used = rsu; d_rt = rt; d_rt_used = rtu;
    d_rd    = rd;  d_wr = wr; d_load = ld;     redirect = redir;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  // Hold an instruction in decode until the model lets it issue; report the
  // stall count and the DUT forward selects seen in its issue cycle.
  task automatic issue(input logic [4:0] rs, input bit rsu, input logic [4:0] rt,
                       input bit rtu, input logic [4:0] rd, input bit wr, input bit ld,
                       output int unsigned stalls, output logic [1:0] frs,
                       output logic [1:0] frt);
    exp_t e;
    bit   done;
    set_in(1'b1, rs, rsu, rt, rtu, rd, wr, ld, 1'b0);
    stalls = 0;
    done   = 1'b0;
    frs    = 2'd0;
    frt    = 2'd0;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge clk);
      e = model();
      if (e.stall) stalls++;
      else begin
        done = 1'b1;
        frs  = fwd_rs;
        frt  = fwd_rt;
      end
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got no issue within 8 cycles expected issue");
    end
  endtask

  int unsigned s;
  logic [1:0]  frs, frt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_stall", 32'(stall_fd), 0);
    check("rst_cnt",   32'(stall_cnt), 0);
    step();

    // ADDI r3,r1 ; ADD r4,r3,r1
    issue(5'd1, 1, 5'd0, 0, 5'd3, 1, 0, s, frs, frt);
    issue(5'd3, 1, 5'd1, 1, 5'd4, 1, 0, s, frs, frt);
    check("e_stalls", s, FWD ? 0 : 3);
    check("e_fwd_rs", 32'(frs), FWD ? 1 : 0);
    check("e_cnt", 32'(stall_cnt), FWD ? 0 : 3);
    idle(3);

    // LW r5,0(r2) ; SW r5,0(r2)
    issue(5'd2, 1, 5'd0, 0, 5'd5, 1, 1, s, frs, frt);
    issue(5'd2, 1, 5'd5, 1, 5'd0, 0, 0, s, frs, frt);
    check("lu_stalls", s, FWD ? 1 : 3);
    check("lu_fwd_rt", 32'(frt), FWD ? 2 : 0);
    check("lu_cnt", 32'(stall_cnt), FWD ? 1 : 6);
    idle(3);

    // ADDI r0,r1 ; ADD r6,r0,r0
    issue(5'd1, 1, 5'd0, 0, 5'd0, 1, 0, s, frs, frt);
    issue(5'd0, 1, 5'd0, 1, 5'd6, 1, 0, s, frs, frt);
    check("r0_stalls", s, 0);
    check("r0_fwd_rs", 32'(frs), 0);
    check("r0_fwd_rt", 32'(frt), 0);
    idle(3);

    // Producer in M at consumer decode
    issue(5'd1, 1, 5'd0, 0, 5'd11, 1, 0, s, frs, frt);
    idle(1);
    issue(5'd11, 1, 5'd2, 1, 5'd12, 1, 0, s, frs, frt);
    check("m_stalls", s, FWD ? 0 : 2);
    check("m_fwd_rs", 32'(frs), FWD ? 2 : 0);
    idle(3);

    // Producer in W at consumer decode
    issue(5'd1, 1, 5'd0, 0, 5'd13, 1, 0, s, frs, frt);
    idle(2);
    issue(5'd2, 1, 5'd13, 1, 5'd14, 1, 0, s, frs, frt);
    check("w_stalls", s, FWD ? 0 : 1);
    check("w_fwd_rt", 32'(frt), FWD ? 3 : 0);
    idle(3);

    // Matching source that is not read
    issue(5'd1, 1, 5'd0, 0, 5'd15, 1, 1, s, frs, frt);
    issue(5'd15, 0, 5'd2, 1, 5'd16, 1, 0, s, frs, frt);
    check("unused_stalls", s, 0);
    check("unused_fwd_rs", 32'(frs), 0);
    check("unused_cnt", 32'(stall_cnt), FWD ? 1 : 9);
    idle(3);

    // Hazard plus redirect, then a second redirect back-to-back
    issue(5'd1, 1, 5'd0, 0, 5'd7, 1, 1, s, frs, frt);
    set_in(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("rd1_flush", 32'(flush_d), 1);
    check("rd1_bubble", 32'(bubble_e), 1);
    check("rd1_stall", 32'(stall_fd), 0);
    step();
    set_in(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("rd2_flush", 32'(flush_d), 1);
    check("rd2_bubble", 32'(bubble_e), 1);
    check("rd2_stall", 32'(stall_fd), 0);
    step();
    idle(3);
    check("rd_cnt", 32'(stall_cnt), FWD ? 1 : 9);

    // Reset during the second stall cycle
    issue(5'd1, 1, 5'd0, 0, 5'd9, 1, FWD, s, frs, frt);
    set_in(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rs_stall", 32'(stall_fd), 0);
    check("rs_bubble", 32'(bubble_e), 0);
    check("rs_flush", 32'(flush_d), 0);
    check("rs_fwd_rs", 32'(fwd_rs), 0);
    check("rs_cnt", 32'(stall_cnt), 0);
    step();
    issue(5'd9, 1, 5'd0, 0, 5'd10, 1, 0, s, frs, frt);
    check("rs_empty_stalls", s, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
